instr_flash: RTL and testbench

INSTR_FLASH -- requirements
Module: instr_flash

---
 rtl/instr_flash_pkg.sv | 22 ++
 rtl/instr_flash_mem.sv | 63 ++++++
 rtl/instr_flash.sv | 145 ++++++++++++++
 tb/tb_instr_flash.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_flash_pkg.sv
// Shared types and default configuration for the instruction flash model.
// Optional feature macro used by this slice: INSTR_FLASH_PARITY_EN.
package instr_flash_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          DEF_DATA_W   = 16;
    localparam int          DEF_ADDR_W   = 12;
    localparam int          DEF_DEPTH    = 256;
    localparam logic [15:0] DEF_NOP_WORD = 16'h0000;

    // Even-parity bit for a 16-bit word; wider words use the reduction directly
    function automatic logic even_par16(input logic [15:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/instr_flash_mem.sv
// Instruction storage: one synchronous write port and one asynchronous read port.
// Writes and reads beyond DEPTH are dropped / flagged; storage is never reset.
// With INSTR_FLASH_PARITY_EN defined, an even-parity bit is kept per word and
// the read port reports a mismatch between the stored word and its bit.
module instr_flash_mem
    import instr_flash_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_oob,
    output logic              o_par_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [IDX_W-1:0]  w_widx;
    logic [IDX_W-1:0]  w_ridx;

    // Range checks compare one bit wider so DEPTH == 2**ADDR_W stays representable
    assign w_wr_ok = ({1'b0, i_waddr} < DEPTH_L);
    assign w_rd_ok = ({1'b0, i_raddr} < DEPTH_L);
    assign w_widx  = i_waddr[IDX_W-1:0];
    assign w_ridx  = i_raddr[IDX_W-1:0];

    // Word write; out-of-range addresses are silently dropped
    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_mem[w_widx] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_mem[w_ridx] : '0;
    assign o_oob   = !w_rd_ok;

`ifdef INSTR_FLASH_PARITY_EN
    logic r_par [DEPTH];

    // Parity bit written alongside the word so that word+bit has even weight
    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_par[w_widx] <= ^i_wdata;
        end
    end

    assign o_par_err = w_rd_ok && ((^r_mem[w_ridx]) != r_par[w_ridx]);
`else
    assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/instr_flash.sv
// Instruction flash with programmable wait states per fetch.
// Fetch FSM IDLE -> (WAIT) -> RESP; data_valid strobes in RESP for one cycle.
// Optional parity checking is enabled by defining INSTR_FLASH_PARITY_EN.
module instr_flash
    import instr_flash_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wait_cfg,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              oob_err,
    output logic              par_err,
    input  logic              err_clr
);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_out;
    logic              r_oob_err;
    logic              r_par_err;

    logic              w_accept;
    logic              w_load;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_rd_oob;
    logic              w_rd_par_err;

    // A fetch is accepted only from IDLE or RESP, and never while programming
    assign w_accept = req && !prog_en && ((r_state == ST_IDLE) || (r_state == ST_RESP));

    // The word is captured on the edge that enters RESP; on a zero-wait accept the
    // address has not been latched yet, so the live address is read instead.
    assign w_load    = (w_next_state == ST_RESP);
    assign w_rd_addr = (r_state == ST_WAIT) ? r_addr : addr;

    instr_flash_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_we      (prog_we),
        .i_waddr   (prog_addr),
        .i_wdata   (prog_data),
        .i_raddr   (w_rd_addr),
        .o_rdata   (w_rdata),
        .o_oob     (w_rd_oob),
        .o_par_err (w_rd_par_err)
    );

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; WAIT leaves on the cycle the counter reaches 1
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_next_state = (wait_cfg == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_next_state = (r_cnt <= 4'd1) ? ST_RESP : ST_WAIT;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        data_valid = (r_state == ST_RESP);
        busy       = (r_state == ST_WAIT);
    end

    // Fetch address capture; data only, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= addr;
        end
    end

    // Wait counter: loaded at accept, counts down while waiting
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= wait_cfg;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response word and sticky error flags; a set wins over a same-cycle clear
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_data_out <= NOP_WORD;
            r_oob_err  <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out <= w_rd_oob ? NOP_WORD : w_rdata;
            end
            if (w_load && w_rd_oob) begin
                r_oob_err <= 1'b1;
            end else if (err_clr) begin
                r_oob_err <= 1'b0;
            end
            if (w_load && w_rd_par_err) begin
                r_par_err <= 1'b1;
            end else if (err_clr) begin
                r_par_err <= 1'b0;
            end
        end
    end

    assign data_out = r_data_out;
    assign oob_err  = r_oob_err;
    assign par_err  = r_par_err;

endmodule

// File: tb/tb_instr_flash.sv
// Self-checking bench for instr_flash: randomized programming and fetches
// compared against an array-based memory model with latency rules.
// Optional parity scenario compiled when INSTR_FLASH_PARITY_EN is defined.
module tb_instr_flash;

    localparam int          DW  = 16;
    localparam int          AW  = 12;
    localparam int          DEP = 256;
    localparam logic [15:0] NOP = 16'h0000;

    logic          clk = 1'b0;
    logic          arst;
    logic          req;
    logic [AW-1:0] addr;
    logic [3:0]    wait_cfg;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    logic          prog_en;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic          oob_err;
    logic          par_err;
    logic          err_clr;

    logic [15:0] model_mem [DEP];
    bit          model_oob;
    bit          model_par;
    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;

    instr_flash #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEP),
        .NOP_WORD (NOP)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .req        (req),
        .addr       (addr),
        .wait_cfg   (wait_cfg),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .prog_en    (prog_en),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .oob_err    (oob_err),
        .par_err    (par_err),
        .err_clr    (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [AW-1:0] a);
        if (a < DEP) return model_mem[a[7:0]];
        return NOP;
    endfunction

    task automatic prog(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_en = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0; prog_en = 1'b0;
        if (a < DEP) model_mem[a[7:0]] = d;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_oob = 0;
        model_par = 0;
        chk("clr_oob", oob_err, 0);
        chk("clr_par", par_err, 0);
    endtask

    // One fetch; optional same-cycle write to the fetched address at accept
    task automatic do_fetch(input logic [AW-1:0] a, input logic [3:0] w,
                            input bit same_wr, input logic [15:0] wr_d);
        logic [15:0] exp;
        int n;
        int bcnt;
        exp = model_read(a);
        if (a >= DEP) model_oob = 1;
        @(negedge clk);
        req = 1'b1; addr = a; wait_cfg = w;
        if (same_wr) begin
            prog_we = 1'b1; prog_addr = a; prog_data = wr_d;
        end
        @(negedge clk);
        req = 1'b0; prog_we = 1'b0;
        if (same_wr && a < DEP) model_mem[a[7:0]] = wr_d;
        addr = AW'($urandom);
        wait_cfg = 4'($urandom);
        prog_en = 1'($urandom_range(0, 1));
        n = 1;
        bcnt = 0;
        while (data_valid !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            n++;
        end
        chk("latency", n, int'(w) + 1);
        chk("busy_cycles", bcnt, int'(w));
        chk("busy_in_resp", busy, 0);
        chk("data", data_out, exp);
        chk("oob", oob_err, model_oob);
        chk("par", par_err, model_par);
        @(negedge clk);
        prog_en = 1'b0;
        chk("dv_single", data_valid, 0);
        chk("data_hold", data_out, exp);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [15:0]   old0;
        bit            seen;

        arst = 1'b1; req = 1'b0; addr = '0; wait_cfg = '0;
        prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; err_clr = 1'b0;
        model_oob = 0; model_par = 0;
        repeat (2) @(negedge clk);
        chk("rst_dv", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_out, NOP);
        chk("rst_oob", oob_err, 0);
        chk("rst_par", par_err, 0);
        arst = 1'b0;

        // Fill the whole memory with random words
        for (int i = 0; i < DEP; i++) begin
            @(negedge clk);
            prog_en = 1'b1; prog_we = 1'b1;
            prog_addr = AW'(i);
            d = 16'($urandom);
            prog_data = d;
            model_mem[i] = d;
        end
        @(negedge clk);
        prog_we = 1'b0; prog_en = 1'b0;

        // Program-then-fetch of a known word
        prog(12'h005, 16'h60FF);
        do_fetch(12'h005, 4'd0, 0, 16'h0);

        // Out-of-range write must not alias onto word 0
        old0 = model_mem[0];
        prog(12'h100, ~old0);
        do_fetch(12'h000, 4'd0, 0, 16'h0);

        // Three-wait fetch
        do_fetch(AW'($urandom_range(0, DEP - 1)), 4'd3, 0, 16'h0);

        // Back-to-back zero-wait fetches of 0,1,2
        @(negedge clk);
        req = 1'b1; addr = 12'h000; wait_cfg = 4'd0;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_dv", data_valid, 1);
            chk("b2b_data", data_out, model_mem[i - 1]);
            addr = AW'(i);
        end
        @(negedge clk);
        chk("b2b_dv", data_valid, 1);
        chk("b2b_data", data_out, model_mem[2]);
        req = 1'b0;
        @(negedge clk);
        chk("b2b_end", data_valid, 0);

        // Out-of-range fetch, then clear
        do_fetch(12'h100, 4'd0, 0, 16'h0);
        clear_errs();

        // Out-of-range set together with a clear: the set wins
        @(negedge clk);
        req = 1'b1; addr = 12'h200; wait_cfg = 4'd0; err_clr = 1'b1;
        @(negedge clk);
        req = 1'b0; err_clr = 1'b0;
        chk("setclr_dv", data_valid, 1);
        chk("setclr_oob", oob_err, 1);
        model_oob = 1;
        clear_errs();

        // Same-cycle write and fetch returns the old word
        do_fetch(12'h009, 4'd0, 1, ~model_mem[9]);
        do_fetch(12'h009, 4'd1, 0, 16'h0);

        // Request while programming is ignored
        @(negedge clk);
        req = 1'b1; prog_en = 1'b1; addr = 12'h003; wait_cfg = 4'd0;
        @(negedge clk);
        chk("blk_dv", data_valid, 0);
        chk("blk_busy", busy, 0);
        req = 1'b0; prog_en = 1'b0;
        @(negedge clk);
        chk("blk_dv2", data_valid, 0);

        // Randomized mix of writes, fetches and clears
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                prog(AW'($urandom_range(0, 511)), 16'($urandom));
            end
            if ($urandom_range(0, 9) == 0) a = AW'($urandom_range(DEP, 4095));
            else a = AW'($urandom_range(0, DEP - 1));
            do_fetch(a, 4'($urandom_range(0, 15)), 0, 16'h0);
            if ($urandom_range(0, 7) == 0) clear_errs();
        end

        // Reset in the second wait cycle of a five-wait fetch
        do_fetch(12'h100, 4'd0, 0, 16'h0);
        do_fetch(12'h005, 4'd0, 0, 16'h0);
        a = AW'($urandom_range(0, DEP - 1));
        @(negedge clk);
        req = 1'b1; addr = a; wait_cfg = 4'd5;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("rstw_busy", busy, 1);
        arst = 1'b1;
        #1;
        chk("rstw_dv", data_valid, 0);
        chk("rstw_busy0", busy, 0);
        chk("rstw_data", data_out, NOP);
        chk("rstw_oob", oob_err, 0);
        model_oob = 0;
        model_par = 0;
        @(negedge clk);
        arst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (data_valid === 1'b1) seen = 1;
        end
        chk("rstw_no_dv", seen, 0);
        chk("rstw_data_hold", data_out, NOP);
        do_fetch(a, 4'd2, 0, 16'h0);
        do_fetch(12'h005, 4'd0, 0, 16'h0);

`ifdef INSTR_FLASH_PARITY_EN
        // Corrupt a stored parity bit: word still delivered, parity flag raised
        prog(12'h007, 16'h1234);
        dut.u_mem.r_par[7] = ~dut.u_mem.r_par[7];
        model_par = 1;
        do_fetch(12'h007, 4'd1, 0, 16'h0);
        clear_errs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
